// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: valid/ready word intake, runtime baud divisor, DATA_BITS/STOP_BITS framing.
// Optional parity bit enabled by defining UART_TX_PARITY_EN (adds parity_en/parity_odd ports and PARITY state).
module uart_tx_param #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int DIV_W     = 16
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 uart_txd,
`ifdef UART_TX_PARITY_EN
    input  logic                 parity_en,
    input  logic                 parity_odd,
`endif
    output logic [2:0]           dbg_state_o
);

    // Handshake: a word is accepted on a rising edge where tx_valid && tx_ready.
    // tx_ready is high only in IDLE; tx_valid seen while busy is dropped, not queued.

    localparam int IDX_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [DIV_W-1:0]     cnt_q, cnt_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
`endif

    logic cnt_last;
    logic last_stop;

    assign cnt_last  = (cnt_q == div_q - DIV_W'(1));
    assign last_stop = (stop_q == 1'(STOP_BITS - 1));

    // State register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            idx_q     <= '0;
            stop_q    <= 1'b0;
            shift_q   <= '0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            idx_q     <= idx_d;
            stop_q    <= stop_d;
            shift_q   <= shift_d;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
`endif
        end
    end

    // Next-state logic; the bit-period counter wraps to 0 at div_eff-1
    always_comb begin
        state_d   = state_q;
        cnt_d     = (state_q == S_IDLE || cnt_last) ? '0 : cnt_q + DIV_W'(1);
        div_d     = div_q;
        idx_d     = idx_q;
        stop_d    = stop_q;
        shift_d   = shift_q;
`ifdef UART_TX_PARITY_EN
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    state_d   = S_START;
                    idx_d     = '0;
                    stop_d    = 1'b0;
                    shift_d   = tx_data;
                    // Divisors below 2 are clamped so every bit lasts at least two cycles
                    div_d     = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
`ifdef UART_TX_PARITY_EN
                    par_en_d  = parity_en;
                    par_bit_d = (^tx_data) ^ parity_odd;
`endif
                end
            end
            S_START: begin
                if (cnt_last) state_d = S_DATA;
            end
            S_DATA: begin
                if (cnt_last) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = par_en_q ? S_PARITY : S_STOP;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (cnt_last) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (cnt_last) begin
                    if (last_stop) state_d = S_IDLE;
                    else           stop_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from registered state only
    always_comb begin
        tx_ready    = (state_q == S_IDLE);
        tx_busy     = (state_q != S_IDLE);
        tx_done     = (state_q == S_STOP) && cnt_last && last_stop;
        dbg_state_o = state_q;
        case (state_q)
            S_START:  uart_txd = 1'b0;
            S_DATA:   uart_txd = shift_q[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: uart_txd = par_bit_q;
`endif
            default:  uart_txd = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: an 8N1 instance and a 5-data/2-stop instance share clock and reset.
// Parity frames are exercised only when UART_TX_PARITY_EN is defined.
module tb_uart_tx_param;

    logic        clk;
    logic        rst;

    logic [15:0] b8, b5;
    logic        v8, v5;
    logic [7:0]  d8;
    logic [4:0]  d5;
    logic        rdy8, bsy8, dn8, txd8;
    logic        rdy5, bsy5, dn5, txd5;
    logic [2:0]  st8, st5;
`ifdef UART_TX_PARITY_EN
    logic        pe8, po8, pe5, po5;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    logic exp_q[$];

    uart_tx_param #(.DATA_BITS(8), .STOP_BITS(1), .DIV_W(16)) dut8 (
        .sys_clk(clk), .sys_rst(rst), .baud_div(b8), .tx_valid(v8), .tx_data(d8),
        .tx_ready(rdy8), .tx_busy(bsy8), .tx_done(dn8), .uart_txd(txd8),
`ifdef UART_TX_PARITY_EN
        .parity_en(pe8), .parity_odd(po8),
`endif
        .dbg_state_o(st8)
    );

    uart_tx_param #(.DATA_BITS(5), .STOP_BITS(2), .DIV_W(16)) dut5 (
        .sys_clk(clk), .sys_rst(rst), .baud_div(b5), .tx_valid(v5), .tx_data(d5),
        .tx_ready(rdy5), .tx_busy(bsy5), .tx_done(dn5), .uart_txd(txd5),
`ifdef UART_TX_PARITY_EN
        .parity_en(pe5), .parity_odd(po5),
`endif
        .dbg_state_o(st5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Sends one word, then tracks the line cycle by cycle until tx_ready returns.
    // Data, divisor and parity inputs are disturbed right after the accept edge.
    task automatic frame(input bit sel, input logic [7:0] d, input logic [15:0] div,
                         input logic [15:0] div_after, input bit hold, input bit pe,
                         input bit po, input string tag, input int exp_len);
        int nb, ns, de, mism, len, done_at, done_n;
        nb = sel ? 5 : 8;
        ns = sel ? 2 : 1;
        de = (div < 2) ? 2 : int'(div);
        exp_q.delete();
        repeat (de) exp_q.push_back(1'b0);
        for (int i = 0; i < nb; i++) repeat (de) exp_q.push_back(d[i]);
        if (pe) repeat (de) exp_q.push_back((^d) ^ po);
        repeat (ns * de) exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);

        if (sel) begin d5 = d[4:0]; b5 = div; v5 = 1'b1; end
        else     begin d8 = d;      b8 = div; v8 = 1'b1; end
`ifdef UART_TX_PARITY_EN
        if (sel) begin pe5 = pe; po5 = po; end
        else     begin pe8 = pe; po8 = po; end
`endif
        @(posedge clk); #1;
        if (sel) begin d5 = ~d[4:0]; b5 = div_after; v5 = hold; end
        else     begin d8 = ~d;      b8 = div_after; v8 = hold; end
`ifdef UART_TX_PARITY_EN
        if (sel) begin pe5 = ~pe; po5 = ~po; end
        else     begin pe8 = ~pe; po8 = ~po; end
`endif

        mism = 0; len = -1; done_at = -1; done_n = 0;
        for (int c = 1; c <= 400; c++) begin
            logic txd, rdy, dn;
            txd = sel ? txd5 : txd8;
            rdy = sel ? rdy5 : rdy8;
            dn  = sel ? dn5  : dn8;
            if (exp_q.size() == 0) mism++;
            else if (txd !== exp_q.pop_front()) mism++;
            if (dn) begin done_n++; done_at = c; end
            if (rdy) begin len = c - 1; break; end
            @(posedge clk); #1;
        end
        chk({tag, "_wave"}, mism, 0);
        chk({tag, "_len"}, len, exp_len);
        chk({tag, "_done_at"}, done_at, exp_len);
        chk({tag, "_done_n"}, done_n, 1);
    endtask

    initial begin
        int lows;
        rst = 1'b1;
        v8 = 1'b0; v5 = 1'b0; d8 = '0; d5 = '0; b8 = 16'd4; b5 = 16'd2;
`ifdef UART_TX_PARITY_EN
        pe8 = 1'b0; po8 = 1'b0; pe5 = 1'b0; po5 = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txd8", txd8, 1);
        chk("rst_ready8", rdy8, 1);
        chk("rst_busy8", bsy8, 0);
        chk("rst_done8", dn8, 0);
        chk("rst_state8", st8, 0);
        chk("rst_txd5", txd5, 1);
        chk("rst_busy5", bsy5, 0);
        chk("rst_state5", st5, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_txd8", txd8, 1);

        // A5 at div 4: 0 | 1,0,1,0,0,1,0,1 | 1, 40 busy cycles
        frame(1'b0, 8'hA5, 16'd4, 16'd4, 1'b0, 1'b0, 1'b0, "a5_div4", 40);
        // Held valid: frames at div 3 separated by one idle-high cycle
        frame(1'b0, 8'h00, 16'd3, 16'd3, 1'b1, 1'b0, 1'b0, "b2b_00", 30);
        frame(1'b0, 8'hFF, 16'd3, 16'd3, 1'b0, 1'b0, 1'b0, "b2b_ff", 30);
        // Divisors 0 and 1 clamp to 2
        frame(1'b0, 8'h3C, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, "div0", 20);
        frame(1'b0, 8'hC3, 16'd1, 16'd1, 1'b0, 1'b0, 1'b0, "div1", 20);
        // Divisor raised mid-frame: current frame keeps 4, next uses 8
        frame(1'b0, 8'h5A, 16'd4, 16'd8, 1'b0, 1'b0, 1'b0, "div4_mid", 40);
        frame(1'b0, 8'h81, 16'd8, 16'd8, 1'b0, 1'b0, 1'b0, "div8", 80);
        // 5 data, 2 stop, div 2, 13h: 0,1,1,0,0,1,1,1
        frame(1'b1, 8'h13, 16'd2, 16'd2, 1'b0, 1'b0, 1'b0, "d5s2", 16);
`ifdef UART_TX_PARITY_EN
        // 07h has three ones: even parity bit 1, odd parity bit 0
        frame(1'b0, 8'h07, 16'd4, 16'd4, 1'b0, 1'b1, 1'b0, "par_even", 44);
        frame(1'b0, 8'h07, 16'd4, 16'd4, 1'b0, 1'b1, 1'b1, "par_odd", 44);
`endif

        // Reset mid-frame while data bit 1 (low) of 55h is on the line
        d8 = 8'h55; b8 = 16'd4; v8 = 1'b1;
        @(posedge clk); #1;
        v8 = 1'b0;
        chk("abort_state_start", st8, 1);
        chk("abort_busy_before", bsy8, 1);
        repeat (9) @(posedge clk);
        #1;
        chk("abort_txd_before", txd8, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_txd", txd8, 1);
        chk("abort_ready", rdy8, 1);
        chk("abort_done", dn8, 0);
        chk("abort_busy", bsy8, 0);
        lows = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (txd8 !== 1'b1) lows++;
        end
        rst = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (txd8 !== 1'b1) lows++;
        end
        chk("abort_quiet", lows, 0);
        chk("abort_ready_after", rdy8, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
